// File: rtl/fir_pkg.sv
// Shared definitions for the FIR MAC sequencer: default sizes and FSM state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fir_pkg;

    localparam int FIR_N_TAPS = 4;   // number of filter taps (2..16)
    localparam int FIR_DW     = 16;  // signed sample / coefficient width
    localparam int FIR_ACCW   = 32;  // signed accumulator / output width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } fir_state_e;

endpackage

// File: rtl/fir_mac_sequencer_if.sv
// Handshake/bus bundle between a sample source/result sink (master) and the sequencer (slave).
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready for samples, out_valid/out_ready for results.
// Signals: coef_we/coef_addr/coef_wdata (coefficient write), in_valid/in_ready/x_in (sample in),
//          out_valid/out_ready/y_out (result out), busy (sequencer not idle).
interface fir_mac_sequencer_if
    import fir_pkg::*;
#(
    parameter int N_TAPS = FIR_N_TAPS,
    parameter int DW     = FIR_DW,
    parameter int ACCW   = FIR_ACCW
);
    localparam int AW = $clog2(N_TAPS);

    logic                   coef_we;
    logic [AW-1:0]          coef_addr;
    logic signed [DW-1:0]   coef_wdata;
    logic                   in_valid;
    logic                   in_ready;
    logic signed [DW-1:0]   x_in;
    logic                   out_valid;
    logic                   out_ready;
    logic signed [ACCW-1:0] y_out;
    logic                   busy;

    modport master (
        output coef_we, coef_addr, coef_wdata, in_valid, x_in, out_ready,
        input  in_ready, out_valid, y_out, busy
    );

    modport slave (
        input  coef_we, coef_addr, coef_wdata, in_valid, x_in, out_ready,
        output in_ready, out_valid, y_out, busy
    );

endinterface

// File: rtl/fir_mac_unit.sv
// Signed multiply-accumulate: combinational full-width product, registered wrapping accumulator.
// Latency: one cycle from operands to accumulator; acc_sum is the combinational next sum.
// Backpressure: none; en holds the accumulator, clr zeroes it (clr wins).
// Ports: clk, reset (async, active-high), clr, en, a, b (DW signed), acc_sum (ACCW signed).
module fir_mac_unit
    import fir_pkg::*;
#(
    parameter int DW   = FIR_DW,
    parameter int ACCW = FIR_ACCW
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clr,
    input  logic                   en,
    input  logic signed [DW-1:0]   a,
    input  logic signed [DW-1:0]   b,
    output logic signed [ACCW-1:0] acc_sum
);

    logic signed [2*DW-1:0] prod;
    logic signed [ACCW-1:0] acc_q;
    logic signed [ACCW-1:0] acc_d;

    always_comb begin
        // Widen both operands first so the product is exact at 2*DW bits.
        prod    = (2*DW)'(a) * (2*DW)'(b);
        // Sign-extend into the accumulator; the sum wraps modulo 2^ACCW.
        acc_sum = acc_q + ACCW'(prod);
        acc_d   = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_sum;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR: one shared MAC walks N_TAPS taps per accepted sample.
// Latency: out_valid rises N_TAPS cycles after the accepting edge; one sample per N_TAPS+2 cycles.
// Backpressure: in_ready only in IDLE; result held in OUT until out_ready.
// Ports: clk, reset (async, active-high), bus (fir_mac_sequencer_if.slave).
module fir_mac_sequencer
    import fir_pkg::*;
#(
    parameter int N_TAPS = FIR_N_TAPS,
    parameter int DW     = FIR_DW,
    parameter int ACCW   = FIR_ACCW
) (
    input  logic                  clk,
    input  logic                  reset,
    fir_mac_sequencer_if.slave    bus
);

    localparam int            AW       = $clog2(N_TAPS);
    localparam logic [AW-1:0] LAST_TAP = AW'(N_TAPS - 1);

    fir_state_e             state_q, state_d;
    logic [AW-1:0]          tap_q, tap_d;
    logic signed [DW-1:0]   d_q [N_TAPS];
    logic signed [DW-1:0]   d_d [N_TAPS];
    logic signed [DW-1:0]   h_q [N_TAPS];
    logic signed [DW-1:0]   h_d [N_TAPS];
    logic signed [ACCW-1:0] y_q, y_d;
    logic signed [ACCW-1:0] acc_sum;

    logic accept;
    logic out_fire;
    logic last_tap;
    logic mac_en;

    assign accept   = bus.in_valid && bus.in_ready;
    assign out_fire = bus.out_valid && bus.out_ready;
    assign mac_en   = (state_q == MAC);
    assign last_tap = mac_en && (tap_q == LAST_TAP);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept)   state_d = MAC;
            MAC:     if (last_tap) state_d = OUT;
            OUT:     if (out_fire) state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == OUT);
        bus.busy      = (state_q != IDLE);
        bus.y_out     = y_q;
    end

    // Datapath: coefficient file, delay line, tap counter, result register
    always_comb begin
        d_d   = d_q;
        h_d   = h_q;
        tap_d = tap_q;
        y_d   = y_q;

        // Writes land before any MAC cycle reads them, so a sample accepted
        // in the same cycle already sees the new coefficient.
        if ((state_q == IDLE) && bus.coef_we && (int'(bus.coef_addr) < N_TAPS)) begin
            h_d[bus.coef_addr] = bus.coef_wdata;
        end

        if (accept) begin
            for (int i = N_TAPS - 1; i > 0; i--) begin
                d_d[i] = d_q[i-1];
            end
            d_d[0] = bus.x_in;
            tap_d  = '0;
        end else if (mac_en) begin
            tap_d = tap_q + AW'(1);
        end

        // Capture the completed sum as the last tap is added; the accumulator
        // is cleared on the next accept, so y must keep its own copy.
        if (last_tap) begin
            y_d = acc_sum;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tap_q <= '0;
            y_q   <= '0;
            for (int i = 0; i < N_TAPS; i++) begin
                d_q[i] <= '0;
                h_q[i] <= '0;
            end
        end else begin
            tap_q <= tap_d;
            y_q   <= y_d;
            d_q   <= d_d;
            h_q   <= h_d;
        end
    end

    fir_mac_unit #(
        .DW   (DW),
        .ACCW (ACCW)
    ) u_mac (
        .clk     (clk),
        .reset   (reset),
        .clr     (accept),
        .en      (mac_en),
        .a       (d_q[tap_q]),
        .b       (h_q[tap_q]),
        .acc_sum (acc_sum)
    );

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer with N_TAPS=4, DW=16, ACCW=32.
// Latency: n/a.
// Backpressure: exercised by holding out_ready low while a result is pending.
module tb_fir_mac_sequencer;

    logic clk;
    logic reset;

    int n_vec  = 0;
    int n_miss = 0;

    localparam logic signed [15:0] M = 16'sh8000;

    fir_mac_sequencer_if #(.N_TAPS(4), .DW(16), .ACCW(32)) bus ();

    fir_mac_sequencer #(.N_TAPS(4), .DW(16), .ACCW(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge while idle; returns at a negedge.
    task automatic wr_coef(input logic [1:0] addr, input logic signed [15:0] data);
        bus.coef_we    = 1'b1;
        bus.coef_addr  = addr;
        bus.coef_wdata = data;
        @(negedge clk);
        bus.coef_we    = 1'b0;
    endtask

    task automatic set_h(input logic signed [15:0] h0, h1, h2, h3);
        wr_coef(2'd0, h0);
        wr_coef(2'd1, h1);
        wr_coef(2'd2, h2);
        wr_coef(2'd3, h3);
    endtask

    // Counts posedges after the accepting edge until out_valid, bounded.
    task automatic wait_out(output int k);
        k = 0;
        while (!bus.out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
    endtask

    // Offer one sample (out_ready high), check latency and result, complete the handshake.
    // Any coef write the caller set up lands on the accepting edge; busy_wr tries a write during MAC.
    task automatic send(input string tag, input logic signed [15:0] x,
                        input logic [31:0] exp, input bit busy_wr);
        int k;
        chk({tag, "_in_ready"}, bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.x_in     = x;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.coef_we  = 1'b0;
        k = 0;
        if (busy_wr) begin
            bus.coef_we    = 1'b1;
            bus.coef_addr  = 2'd0;
            bus.coef_wdata = 16'sd7;
            @(negedge clk);
            k = 1;
            bus.coef_we    = 1'b0;
        end
        while (!bus.out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_latency"}, k, 4);
        chk({tag, "_y"}, bus.y_out, exp);
        @(negedge clk);
    endtask

    initial begin
        int k;
        bus.coef_we    = 1'b0;
        bus.coef_addr  = '0;
        bus.coef_wdata = '0;
        bus.in_valid   = 1'b0;
        bus.x_in       = '0;
        bus.out_ready  = 1'b1;
        reset          = 1'b1;
        repeat (2) @(negedge clk);

        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_y_out",     bus.y_out,     0);
        chk("rst_busy",      bus.busy,      0);
        chk("rst_in_ready",  bus.in_ready,  1);
        reset = 1'b0;
        @(negedge clk);

        // Impulse response
        set_h(16'sd1, 16'sd2, 16'sd3, 16'sd4);
        send("imp0", 16'sd1, 32'd1, 1'b0);
        send("imp1", 16'sd0, 32'd2, 1'b0);
        send("imp2", 16'sd0, 32'd3, 1'b0);
        send("imp3", 16'sd0, 32'd4, 1'b0);

        // Step response (the old impulse shifts out on the first step sample)
        send("step0", 16'sd1, 32'd1,  1'b0);
        send("step1", 16'sd1, 32'd3,  1'b0);
        send("step2", 16'sd1, 32'd6,  1'b0);
        send("step3", 16'sd1, 32'd10, 1'b0);

        // Backpressure: d={0,1,1,1} -> 9; a held sample of 5 must wait for the handshake
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.x_in      = 16'sd0;
        @(negedge clk);
        bus.x_in      = 16'sd5;
        wait_out(k);
        chk("bp_latency", k, 4);
        chk("bp_y", bus.y_out, 32'd9);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", bus.out_valid, 1);
            chk("bp_hold_y",     bus.y_out,     32'd9);
            chk("bp_hold_rdy",   bus.in_ready,  0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_idle_rdy",   bus.in_ready,  1);
        chk("bp_idle_valid", bus.out_valid, 0);
        chk("bp_idle_y",     bus.y_out,     32'd9);
        @(negedge clk);
        chk("bp_accept_busy", bus.busy, 1);
        bus.in_valid = 1'b0;
        wait_out(k);
        chk("bp_next_latency", k, 4);
        chk("bp_next_y", bus.y_out, 32'd12);
        @(negedge clk);

        // Flush the 5 through, then an impulse while a coef write is attempted mid-MAC
        send("flush0", 16'sd0, 32'd14, 1'b0);
        send("flush1", 16'sd0, 32'd15, 1'b0);
        send("flush2", 16'sd0, 32'd20, 1'b0);
        send("busywr", 16'sd1, 32'd1,  1'b1);
        send("busywr_next", 16'sd0, 32'd2, 1'b0);

        // Reset in the middle of MAC at tap 2
        bus.in_valid = 1'b1;
        bus.x_in     = 16'sd3;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_busy_before", bus.busy, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_y_out",     bus.y_out,     0);
        chk("midrst_busy",      bus.busy,      0);
        chk("midrst_in_ready",  bus.in_ready,  1);
        reset = 1'b0;
        @(negedge clk);

        // Coefficients are zero after reset
        send("zimp0", 16'sd1, 32'd0, 1'b0);
        send("zimp1", 16'sd0, 32'd0, 1'b0);
        send("zimp2", 16'sd0, 32'd0, 1'b0);
        send("zimp3", 16'sd0, 32'd0, 1'b0);

        // Rewritten coefficients reproduce the impulse response
        set_h(16'sd1, 16'sd2, 16'sd3, 16'sd4);
        send("rimp0", 16'sd1, 32'd1, 1'b0);
        send("rimp1", 16'sd0, 32'd2, 1'b0);
        send("rimp2", 16'sd0, 32'd3, 1'b0);
        send("rimp3", 16'sd0, 32'd4, 1'b0);

        // Modulo-2^32 wrap with full-scale negative operands
        set_h(M, M, M, M);
        send("wrap0", M, 32'h4000_0000, 1'b0);
        send("wrap1", M, 32'h8000_0000, 1'b0);
        send("wrap2", M, 32'hC000_0000, 1'b0);
        send("wrap3", M, 32'h0000_0000, 1'b0);

        // Write and accept in the same cycle: h0 becomes 5 for this sample.
        // d={2,M,M,M}, h={5,2,3,4}: 10 + 9*(-32768) = 0xFFFB800A
        set_h(16'sd1, 16'sd2, 16'sd3, 16'sd4);
        bus.coef_we    = 1'b1;
        bus.coef_addr  = 2'd0;
        bus.coef_wdata = 16'sd5;
        send("samewr", 16'sd2, 32'hFFFB_800A, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/fir_mac_sequencer.md
FIR_MAC_SEQUENCER -- requirements
Module: fir_mac_sequencer

Interface
REQ-001 Parameter N_TAPS, default 4: number of filter taps, range 2..16.
REQ-002 Parameter DW, default 16: signed sample and coefficient width.
REQ-003 Parameter ACCW, default 32: signed accumulator and output width.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 coef_we  in  1  coefficient write strobe.
REQ-007 coef_addr  in  clog2(N_TAPS)  coefficient index.
REQ-008 coef_wdata  in  DW  signed coefficient value.
REQ-009 in_valid  in  1  sample offered.
REQ-010 in_ready  out  1  sequencer accepts a sample.
REQ-011 x_in  in  DW  signed input sample.
REQ-012 out_valid  out  1  y_out holds a finished result.
REQ-013 out_ready  in  1  downstream accepts the result.
REQ-014 y_out  out  ACCW  signed filter output.
REQ-015 busy  out  1  high in any state other than IDLE.

Function
REQ-016 Single shared multiplier; FSM states IDLE, MAC, OUT.
REQ-017 IDLE: in_ready=1; on in_valid&&in_ready, shift delay line (d[i]<=d[i-1], d[0]<=x_in), clear acc, clear tap counter, go to MAC.
REQ-018 MAC: each cycle acc <= acc + d[tap]*h[tap]; tap increments; after tap N_TAPS-1 is added, go to OUT.
REQ-019 OUT: out_valid=1, y_out=acc; held stable until out_valid&&out_ready, then return to IDLE.
REQ-020 Latency: out_valid rises exactly N_TAPS cycles after the accepting edge; with out_ready tied high, throughput is one sample per N_TAPS+2 cycles.
REQ-021 in_ready=0 in MAC and OUT; in_valid in those states is ignored, and no sample is lost provided the source holds in_valid.
REQ-022 Products are full 2*DW signed; sign-extended to ACCW; sum wraps modulo 2^ACCW (no saturation).
REQ-023 Coefficient write is honoured only in IDLE; coef_we in MAC or OUT is silently dropped.
REQ-024 Write and sample accept in the same IDLE cycle: write is applied, and that sample uses the new coefficient.
REQ-025 coef_addr >= N_TAPS: write ignored.
REQ-026 y_out changes only on the MAC->OUT transition; it holds the last result while in IDLE.

Reset
REQ-027 reset forces IDLE in any state, including mid-MAC; the partial result is discarded.
REQ-028 Reset values: out_valid=0, y_out=0, busy=0, in_ready=1 (combinational from IDLE), acc=0, tap=0, all d[i]=0, all h[i]=0.

Structure
REQ-029 Shared package fir_pkg holds DW/ACCW/N_TAPS defaults and the state enumeration (IDLE, MAC, OUT).
REQ-030 One sub-module, fir_mac_unit: a combinational signed multiply plus a registered accumulator with clear and enable inputs; the FSM, coefficient file and delay line live in fir_mac_sequencer.

Verification
REQ-031 Impulse: h={1,2,3,4}, inputs 1,0,0,0 -> y_out 1,2,3,4, each out_valid exactly 4 cycles after its accept.
REQ-032 Step: h={1,2,3,4}, inputs 1,1,1,1 -> y_out 1,3,6,10.
REQ-033 Backpressure: out_ready low 5 cycles in OUT -> y_out and out_valid stable, in_ready=0, held in_valid sample accepted only after the handshake.
REQ-034 Busy write: coef_we addr 0 data 7 during MAC -> dropped; the next impulse still yields first output 1.
REQ-035 Wrap: all h=-32768, inputs -32768 x4 -> y_out 0x40000000, 0x80000000, 0xC0000000, 0x00000000.
REQ-036 Reset mid-MAC (tap 2) -> IDLE next edge, out_valid=0, y_out=0, delay line cleared; the next impulse reproduces REQ-031 only after coefficients are rewritten (h reset to 0 gives all-zero outputs).
